// File: rtl/mult_pipe.sv
// Pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) with tag passthrough,
// global stall on output backpressure and single-cycle flush.
module mult_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_STAGE = 4,
  parameter int unsigned TAG_W     = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       func,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = PW / NUM_STAGE;
  localparam int unsigned LAST = NUM_STAGE - 1;

  logic [NUM_STAGE-1:0] r_valid;
  logic [PW-1:0]        r_a    [NUM_STAGE];
  logic [PW-1:0]        r_b    [NUM_STAGE];
  logic [PW-1:0]        r_sum  [NUM_STAGE];
  logic [1:0]           r_func [NUM_STAGE];
  logic [TAG_W-1:0]     r_tag  [NUM_STAGE];

  logic [PW-1:0]        w_a_in [NUM_STAGE];
  logic [PW-1:0]        w_b_in [NUM_STAGE];
  logic [PW-1:0]        w_s_in [NUM_STAGE];
  logic [PW-1:0]        w_pp   [NUM_STAGE];
  logic [1:0]           w_f_in [NUM_STAGE];
  logic [TAG_W-1:0]     w_t_in [NUM_STAGE];

  logic w_rs1_sgn;
  logic w_rs2_sgn;
  logic w_stall;
  logic w_accept;

  assign w_rs1_sgn = (func == 2'b01) || (func == 2'b10);
  assign w_rs2_sgn = (func == 2'b01);
  assign w_stall   = r_valid[LAST] && !out_ready;
  assign in_ready  = !reset && !flush && !w_stall;
  assign w_accept  = in_valid && in_ready;

  // Stage inputs: stage 0 takes the extended request, later stages chain.
  always_comb begin
    w_a_in = '{default: '0};
    w_b_in = '{default: '0};
    w_s_in = '{default: '0};
    w_f_in = '{default: '0};
    w_t_in = '{default: '0};
    w_a_in[0] = {{XLEN{w_rs1_sgn & rs1[XLEN-1]}}, rs1};
    w_b_in[0] = {{XLEN{w_rs2_sgn & rs2[XLEN-1]}}, rs2};
    w_s_in[0] = '0;
    w_f_in[0] = func;
    w_t_in[0] = in_tag;
    for (int k = 1; k < NUM_STAGE; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_sum[k-1];
      w_f_in[k] = r_func[k-1];
      w_t_in[k] = r_tag[k-1];
    end
  end

  // Each stage multiplies the (pre-shifted) multiplicand by one multiplier chunk.
  always_comb begin
    w_pp = '{default: '0};
    for (int k = 0; k < NUM_STAGE; k++) begin
      w_pp[k] = w_a_in[k] * PW'(w_b_in[k][CW-1:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_valid <= '0;
    end else if (!w_stall) begin
      r_valid[0] <= w_accept;
      for (int k = 1; k < NUM_STAGE; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  // Datapath registers carry no reset; contents of invalid stages are ignored.
  always_ff @(posedge clock) begin
    if (!w_stall) begin
      for (int k = 0; k < NUM_STAGE; k++) begin
        r_a[k]    <= w_a_in[k] << CW;
        r_b[k]    <= w_b_in[k] >> CW;
        r_sum[k]  <= w_s_in[k] + w_pp[k];
        r_func[k] <= w_f_in[k];
        r_tag[k]  <= w_t_in[k];
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign out_tag   = r_tag[LAST];
  assign result    = (r_func[LAST] == 2'b00) ? r_sum[LAST][XLEN-1:0]
                                             : r_sum[LAST][PW-1:XLEN];

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed scenarios on the default
// configuration, randomized runs on 64/8 and 32/2 against an integer model.
module tb_mult_pipe;

  logic clock;
  logic reset;

  logic        flush0, iv0, ir0, ov0, ord0;
  logic [1:0]  f0;
  logic [31:0] a0, b0, res0;
  logic [5:0]  t0, otag0;

  logic        fl_idle;
  logic        iv1, ir1, ov1, ord1;
  logic [1:0]  f1;
  logic [63:0] a1, b1, res1;
  logic [5:0]  t1, ot1;

  logic        iv2, ir2, ov2, ord2;
  logic [1:0]  f2;
  logic [31:0] a2, b2, res2;
  logic [5:0]  t2, ot2;

  int n_checks;
  int n_pass;

  // stall-scenario state
  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [1:0]  sf [8];
  int          sent;
  int          got;
  logic        held_v;
  logic [37:0] held;

  mult_pipe u0 (
    .clock(clock), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .func(f0), .rs1(a0), .rs2(b0), .in_tag(t0), .out_valid(ov0),
    .out_ready(ord0), .result(res0), .out_tag(otag0)
  );

  mult_pipe #(.XLEN(64), .NUM_STAGE(8), .TAG_W(6)) u1 (
    .clock(clock), .reset(reset), .flush(fl_idle), .in_valid(iv1), .in_ready(ir1),
    .func(f1), .rs1(a1), .rs2(b1), .in_tag(t1), .out_valid(ov1),
    .out_ready(ord1), .result(res1), .out_tag(ot1)
  );

  mult_pipe #(.XLEN(32), .NUM_STAGE(2), .TAG_W(6)) u2 (
    .clock(clock), .reset(reset), .flush(fl_idle), .in_valid(iv2), .in_ready(ir2),
    .func(f2), .rs1(a2), .rs2(b2), .in_tag(t2), .out_valid(ov2),
    .out_ready(ord2), .result(res2), .out_tag(ot2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // True integer product of the operands as interpreted by func, then half-select.
  function automatic logic [63:0] ref_mul(input logic [1:0] f, input logic [63:0] a,
                                          input logic [63:0] b, input int xlen);
    logic signed [129:0] sa_v, sb_v, p, one;
    logic [63:0] mask;
    one  = 130'sd1;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sa_v = $signed(130'(a & mask));
    sb_v = $signed(130'(b & mask));
    if ((f == 2'b01 || f == 2'b10) && a[xlen-1]) sa_v = sa_v - (one <<< xlen);
    if (f == 2'b01 && b[xlen-1]) sb_v = sb_v - (one <<< xlen);
    p = sa_v * sb_v;
    if (f == 2'b00) return 64'(p) & mask;
    return 64'(p >>> xlen) & mask;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_8000_0000;
      3:       return 64'h1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Single request on u0 with out_ready high; checks latency, value and tag.
  task automatic issue(input string nm, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] t, input logic [31:0] exp);
    int lat;
    @(negedge clock);
    iv0 = 1'b1; f0 = f; a0 = a; b0 = b; t0 = t; ord0 = 1'b1;
    #1 chk({nm, "_rdy"}, 64'(ir0), 64'd1);
    @(negedge clock);
    iv0 = 1'b0;
    lat = 1;
    while (!ov0 && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd4);
    chk({nm, "_res"}, 64'(res0), 64'(exp));
    chk({nm, "_tag"}, 64'(otag0), 64'(t));
  endtask

  // Random traffic with random backpressure on u1 (cfg 1) or u2 (cfg 2).
  task automatic rand_run(input int cfg, input int xlen);
    logic [63:0] q_res [$];
    logic [5:0]  q_tag [$];
    int acc, cyc;
    logic [63:0] ra, rb, res;
    logic [1:0]  rf;
    logic [5:0]  rt, ot;
    logic        v, r, ovv, irr;
    acc = 0;
    cyc = 0;
    while ((acc < 10000 || q_res.size() > 0) && cyc < 40000) begin
      @(negedge clock);
      cyc++;
      v  = (acc < 10000) && ($urandom_range(0, 4) != 0);
      r  = ($urandom_range(0, 3) != 0);
      rf = 2'($urandom());
      rt = 6'($urandom());
      ra = rnd_op();
      rb = rnd_op();
      if (cfg == 1) begin
        iv1 = v; ord1 = r; f1 = rf; a1 = ra; b1 = rb; t1 = rt;
      end else begin
        iv2 = v; ord2 = r; f2 = rf; a2 = ra[31:0]; b2 = rb[31:0]; t2 = rt;
      end
      #1;
      ovv = (cfg == 1) ? ov1 : ov2;
      irr = (cfg == 1) ? ir1 : ir2;
      res = (cfg == 1) ? res1 : {32'b0, res2};
      ot  = (cfg == 1) ? ot1 : ot2;
      if (ovv && r) begin
        if (q_res.size() == 0) begin
          chk("rand_spurious", 64'(ovv), 64'd0);
        end else begin
          chk("rand_res", res, q_res.pop_front());
          chk("rand_tag", 64'(ot), 64'(q_tag.pop_front()));
        end
      end
      if (v && irr) begin
        q_res.push_back(ref_mul(rf, ra, rb, xlen));
        q_tag.push_back(rt);
        acc++;
      end
    end
    chk("rand_accepted", 64'(acc), 64'd10000);
    chk("rand_drained", 64'(q_res.size()), 64'd0);
    if (cfg == 1) iv1 = 1'b0; else iv2 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    flush0 = 1'b0; iv0 = 1'b0; ord0 = 1'b1; f0 = '0; a0 = '0; b0 = '0; t0 = '0;
    fl_idle = 1'b0;
    iv1 = 1'b0; ord1 = 1'b1; f1 = '0; a1 = '0; b1 = '0; t1 = '0;
    iv2 = 1'b0; ord2 = 1'b1; f2 = '0; a2 = '0; b2 = '0; t2 = '0;

    // reset behaviour
    @(negedge clock);
    @(negedge clock);
    chk("rst_inrdy", 64'(ir0), 64'd0);
    chk("rst_outvalid", 64'(ov0), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_inrdy", 64'(ir0), 64'd1);
    chk("post_rst_inrdy1", 64'(ir1), 64'd1);

    // directed product values
    issue("mul_neg",  2'b00, 32'd7,         32'hFFFF_FFFD, 6'd3, 32'hFFFF_FFEB);
    issue("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 6'd4, 32'h4000_0000);
    issue("mulhsu",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 32'hFFFF_FFFF);
    issue("mulhu",    2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 32'hFFFF_FFFE);

    // back-to-back stream with a three-cycle backpressure window
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom();
      sb[i] = $urandom();
      sf[i] = 2'(i);
    end
    sent = 0;
    got = 0;
    held_v = 1'b0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      ord0 = !(c >= 6 && c < 9);
      iv0 = (sent < 8);
      if (sent < 8) begin
        f0 = sf[sent]; a0 = sa[sent]; b0 = sb[sent]; t0 = 6'(sent);
      end
      #1;
      if (held_v) chk("stall_hold", 64'({ov0, otag0, res0}), 64'({1'b1, held}));
      if (ov0 && !ord0) begin
        chk("stall_inrdy", 64'(ir0), 64'd0);
        held = {otag0, res0};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (ov0 && ord0) begin
        if (got < 8) begin
          chk("seq_tag", 64'(otag0), 64'(got));
          chk("seq_res", 64'(res0), ref_mul(sf[got], 64'(sa[got]), 64'(sb[got]), 32));
        end
        got++;
      end
      if (iv0 && ir0) sent++;
    end
    iv0 = 1'b0;
    ord0 = 1'b1;
    chk("seq_count", 64'(got), 64'd8);
    chk("seq_sent", 64'(sent), 64'd8);

    // flush with three requests in flight and a request presented alongside
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      iv0 = 1'b1; f0 = 2'b00; a0 = 32'(i + 1); b0 = 32'd5; t0 = 6'(10 + i);
    end
    @(negedge clock);
    flush0 = 1'b1; iv0 = 1'b1; a0 = 32'd99; t0 = 6'd20;
    #1 chk("flush_inrdy", 64'(ir0), 64'd0);
    @(negedge clock);
    flush0 = 1'b0; iv0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_quiet", 64'(ov0), 64'd0);
      @(negedge clock);
    end
    issue("post_flush", 2'b11, 32'hFFFF_FFFF, 32'h2, 6'd7, 32'h1);

    // reset with two requests in flight
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      iv0 = 1'b1; f0 = 2'b00; a0 = 32'd3; b0 = 32'd3; t0 = 6'(30 + i);
    end
    @(negedge clock);
    reset = 1'b1; iv0 = 1'b0;
    #1 chk("midrst_inrdy", 64'(ir0), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("midrst_quiet", 64'(ov0), 64'd0);
      @(negedge clock);
    end
    issue("post_reset", 2'b00, 32'd12345, 32'd1000, 6'd9, 32'd12345000);

    // randomized traffic on the other two configurations
    rand_run(1, 64);
    rand_run(2, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand and result width in bits.
REQ-002 SHALL provide parameter NUM_STAGE, default 4, pipeline depth; 2*XLEN SHALL be an integer multiple of NUM_STAGE.
REQ-003 SHALL provide parameter TAG_W, default 6, width of the opaque tag carried alongside each operation.
REQ-004 SHALL provide port: clock  input  1  rising-edge clock.
REQ-005 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port: flush  input  1  squash every in-flight operation.
REQ-007 SHALL provide port: in_valid  input  1  request present.
REQ-008 SHALL provide port: in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-009 SHALL provide port: func  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-010 SHALL provide port: rs1  input  XLEN  multiplicand.
REQ-011 SHALL provide port: rs2  input  XLEN  multiplier.
REQ-012 SHALL provide port: in_tag  input  TAG_W  request tag.
REQ-013 SHALL provide port: out_valid  output  1  result present.
REQ-014 SHALL provide port: out_ready  input  1  consumer accepts result.
REQ-015 SHALL provide port: result  output  XLEN  selected product half.
REQ-016 SHALL provide port: out_tag  output  TAG_W  tag of the result.

Function
REQ-017 SHALL extend operands to 2*XLEN: rs1 signed for MULH/MULHSU, rs2 signed for MULH only, all others zero-extended.
REQ-018 SHALL compute the 2*XLEN product over NUM_STAGE registered stages; each stage SHALL consume 2*XLEN/NUM_STAGE multiplier bits and accumulate into a 2*XLEN partial sum.
REQ-019 SHALL carry func and tag through every stage with the data.
REQ-020 SHALL drive result as product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH, MULHSU, MULHU.
REQ-021 SHALL accept a request when in_valid && in_ready; latency from acceptance edge to out_valid SHALL be exactly NUM_STAGE cycles absent stalls.
REQ-022 SHALL sustain one accepted request per cycle when out_ready is held high.
REQ-023 SHALL stall globally: when out_valid && !out_ready, no stage register SHALL update and in_ready SHALL be low.
REQ-024 SHALL otherwise hold in_ready high, including while the pipeline contains bubbles.
REQ-025 SHALL hold result and out_tag stable while out_valid && !out_ready.
REQ-026 SHALL propagate bubbles: a stage valid bit SHALL be cleared when its upstream stage is empty and the pipeline advances.
REQ-027 SHALL, on flush, clear every stage valid bit at the next edge; a request presented in the flush cycle SHALL be dropped, and in_ready SHALL be low during flush.
REQ-028 SHALL give flush priority over stall and acceptance when asserted in the same cycle.
REQ-029 SHALL produce results in acceptance order; datapath registers for invalid stages are don't-care.

Reset
REQ-030 SHALL, while reset is high, clear all stage valid bits, so out_valid is 0 at the edge after reset.
REQ-031 SHALL drive in_ready low during reset and high in the first cycle after reset deasserts.
REQ-032 SHALL discard operations in flight when reset asserts mid-operation; no result for them SHALL appear.
REQ-033 SHALL NOT require reset of datapath (sum, operand, tag, func) registers.

Verification
REQ-034 MUL rs1=7, rs2=0xFFFFFFFD, tag=3, out_ready=1 -> out_valid 4 cycles later, result 0xFFFFFFEB, out_tag 3.
REQ-035 MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 Eight back-to-back requests tags 0..7, out_ready low for 3 cycles mid-stream -> in_ready low during stall, all 8 results in order, none duplicated or lost, output stable while stalled.
REQ-037 Three requests in flight, flush asserted with in_valid high -> out_valid stays 0 for 6 following cycles; next request completes normally with correct value.
REQ-038 Reset asserted with 2 requests in flight -> out_valid 0 after reset, no stale result emerges, fresh request completes in 4 cycles.
REQ-039 Random func/operands for XLEN=64, NUM_STAGE=8 and XLEN=32, NUM_STAGE=2 against a reference model with random out_ready -> zero mismatches over 10000 requests.
